coord_bcd_converter: RTL and testbench



---
 rtl/coord_bcd_converter.sv | 142 ++++++++++++++
 tb/tb_coord_bcd_converter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/coord_bcd_converter.sv
// Converts three snapshotted binary coordinates to packed BCD with one shared double-dabble engine.
// Latency: done appears 34 cycles after start is sampled (NUM_CH*(DATA_W+1)+1); start is ignored while busy.
module coord_bcd_converter #(
    parameter int DATA_W     = 10,
    parameter int NUM_DIGITS = 4,
    parameter int NUM_CH     = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_W-1:0]       x,
    input  logic [DATA_W-1:0]       y,
    input  logic [DATA_W-1:0]       z,
    output logic                    busy,
    output logic                    done,
    output logic                    valid,
    output logic [4*NUM_DIGITS-1:0] x_bcd,
    output logic [4*NUM_DIGITS-1:0] y_bcd,
    output logic [4*NUM_DIGITS-1:0] z_bcd
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] snap   [NUM_CH];
    logic [BCD_W-1:0]  result [NUM_CH];
    logic [BCD_W-1:0]  bcd_q  [NUM_CH];

    logic [DATA_W-1:0] bin;
    logic [BCD_W-1:0]  scratch;
    logic [BCD_W-1:0]  scratch_adj;
    logic [BCD_W-1:0]  scratch_shift;
    logic [CNT_W-1:0]  cnt;
    logic [CH_W-1:0]   ch;
    logic              last_bit;
    logic              last_ch;

    // Each nibble is corrected on its own; a corrected nibble never exceeds 12, so no carry leaves it.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        scratch_shift = {scratch_adj[BCD_W-2:0], bin[DATA_W-1]};
    end

    assign last_bit = (cnt == CNT_W'(1));
    assign last_ch  = (ch == CH_W'(NUM_CH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = last_ch ? DONE : LOAD;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap[i]   <= '0;
                result[i] <= '0;
                bcd_q[i]  <= '0;
            end
            bin     <= '0;
            scratch <= '0;
            cnt     <= '0;
            ch      <= '0;
            valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        snap[0] <= x;
                        snap[1] <= y;
                        snap[2] <= z;
                        ch      <= '0;
                    end
                end
                LOAD: begin
                    bin     <= snap[ch];
                    scratch <= '0;
                    cnt     <= CNT_W'(DATA_W);
                end
                SHIFT: begin
                    scratch <= scratch_shift;
                    bin     <= {bin[DATA_W-2:0], 1'b0};
                    cnt     <= cnt - CNT_W'(1);
                    if (last_bit) begin
                        result[ch] <= scratch_shift;
                        if (last_ch) begin
                            // Publish all channels together with the edge that raises done.
                            for (int i = 0; i < NUM_CH; i++) begin
                                bcd_q[i] <= (i == NUM_CH - 1) ? scratch_shift : result[i];
                            end
                            valid <= 1'b1;
                        end else begin
                            ch <= ch + CH_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign x_bcd = bcd_q[0];
    assign y_bcd = bcd_q[1];
    assign z_bcd = bcd_q[2];

endmodule

// File: tb/tb_coord_bcd_converter.sv
// Scoreboard bench for coord_bcd_converter: expected digits are queued at start and compared at done.
module tb_coord_bcd_converter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  x, y, z;
    logic        busy, done, valid;
    logic [15:0] x_bcd, y_bcd, z_bcd;

    typedef struct {
        logic [15:0] xb;
        logic [15:0] yb;
        logic [15:0] zb;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    coord_bcd_converter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .z     (z),
        .busy  (busy),
        .done  (done),
        .valid (valid),
        .x_bcd (x_bcd),
        .y_bcd (y_bcd),
        .z_bcd (z_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic exp_t mk_exp(input int xv, input int yv, input int zv);
        exp_t e;
        e.xb = to_bcd(xv);
        e.yb = to_bcd(yv);
        e.zb = to_bcd(zv);
        return e;
    endfunction

    // Pops one expected entry and compares it against the published digits.
    task automatic check_outputs(input string tag);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            $display("FAIL %s scoreboard: done seen with no expected entry queued", tag);
            return;
        end
        e = sb.pop_front();
        if (x_bcd !== e.xb || y_bcd !== e.yb || z_bcd !== e.zb)
            $display("FAIL %s bcd: got x=%h y=%h z=%h expected x=%h y=%h z=%h",
                     tag, x_bcd, y_bcd, z_bcd, e.xb, e.yb, e.zb);
        else passed++;
    endtask

    // One conversion; optionally changes x after chg_at cycles to prove the snapshot.
    task automatic conv(input int xv, input int yv, input int zv,
                        input int chg_at, input int chg_x, input string tag);
        int lat;
        x = 10'(xv); y = 10'(yv); z = 10'(zv);
        start = 1'b1;
        sb.push_back(mk_exp(xv, yv, zv));
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            if (lat == chg_at) x = 10'(chg_x);
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat != 34) $display("FAIL %s latency: got %0d expected 34", tag, lat);
        else passed++;
        check_outputs(tag);
        total++;
        if (busy !== 1'b1 || valid !== 1'b1)
            $display("FAIL %s done_cycle: busy=%b valid=%b expected busy=1 valid=1", tag, busy, valid);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b1)
            $display("FAIL %s after_done: done=%b busy=%b valid=%b expected 0 0 1", tag, done, busy, valid);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start = i[0];
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0)
            $display("FAIL reset_ctrl: busy=%b done=%b valid=%b expected 0 0 0", busy, done, valid);
        else passed++;
        total++;
        if (x_bcd !== 16'h0 || y_bcd !== 16'h0 || z_bcd !== 16'h0)
            $display("FAIL reset_bcd: x=%h y=%h z=%h expected 0000", x_bcd, y_bcd, z_bcd);
        else passed++;
        rst_n = 1'b1;
        x = 10'd123; y = 10'd456; z = 10'd789;
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b0 || valid !== 1'b0 || x_bcd !== 16'h0 || z_bcd !== 16'h0)
            $display("FAIL reset_release: busy=%b valid=%b x=%h z=%h expected idle zeros",
                     busy, valid, x_bcd, z_bcd);
        else passed++;
    endtask

    task automatic test_basic();
        conv(0, 512, 1023, 0, 0, "basic");
        repeat (10) @(negedge clk);
        total++;
        if (valid !== 1'b1 || z_bcd !== 16'h1023)
            $display("FAIL basic_hold: valid=%b z=%h expected 1 1023", valid, z_bcd);
        else passed++;
    endtask

    task automatic test_snapshot();
        conv(999, 1, 2, 5, 7, "snapshot");
        conv(7, 1, 2, 0, 0, "snapshot2");
    endtask

    task automatic test_start_while_busy();
        int ndone = 0;
        x = 10'd321; y = 10'd654; z = 10'd87;
        sb.push_back(mk_exp(321, 654, 87));
        start = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            start = (n == 10 || n == 34) ? 1'b1 : 1'b0;
            if (done === 1'b1) begin
                ndone++;
                check_outputs("busy_start");
            end
        end
        start = 1'b0;
        total++;
        if (ndone != 1) $display("FAIL busy_start_count: got %0d dones expected 1", ndone);
        else passed++;
    endtask

    task automatic test_held_start();
        int first = -1;
        int second = -1;
        int n = 0;
        x = 10'd42; y = 10'd808; z = 10'd1000;
        sb.push_back(mk_exp(42, 808, 1000));
        sb.push_back(mk_exp(42, 808, 1000));
        start = 1'b1;
        while (second < 0 && n < 150) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) begin
                check_outputs("held");
                if (first < 0) first = n;
                else begin
                    second = n;
                    start  = 1'b0;
                end
            end
        end
        start = 1'b0;
        total++;
        if (first != 34 || second != 69)
            $display("FAIL held_timing: got dones at %0d and %0d expected 34 and 69", first, second);
        else passed++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int ndone = 0;
        conv(5, 512, 6, 0, 0, "mid_pre");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0 || y_bcd !== 16'h0)
            $display("FAIL mid_reset: busy=%b valid=%b done=%b y=%h expected 0 0 0 0000",
                     busy, valid, done, y_bcd);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        total++;
        if (ndone != 0 || busy !== 1'b0 || valid !== 1'b0)
            $display("FAIL mid_reset_after: dones=%0d busy=%b valid=%b expected 0 0 0", ndone, busy, valid);
        else passed++;
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 1024; v++) begin
            conv(v, v, v, 0, 0, "sweep");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        x = '0; y = '0; z = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_snapshot();
        test_start_while_busy();
        test_held_start();
        test_mid_reset();
        test_sweep();
        total++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
